// File: rtl/seq_alu_m.sv
// seq_alu_m: multi-cycle RV32I/M ALU with valid/ready handshake and {V,C,N,Z} flags
module seq_alu_m #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_flags,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] int_min = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_n;
  logic [2*XLEN-1:0] acc, step, prod;
  logic [XLEN-1:0] opd, ma, mb, sra, base_res, sum, dv, fin;
  logic [XLEN:0] add_full, msum, rsh, diff;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic neg, fire, m_op, sub, v, cy, asg, bsg, an, bn, dz, ovf, last;

  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign fire = in_valid & in_ready;
  assign busy = state == MUL || state == DIV;
  assign out_valid = state == DONE;
  assign m_op = funct7 == 7'b0000001;
  // SLT/SLTU reuse the subtractor so their flags describe a - b
  assign sub = (funct3 == 3'b000 && funct7[5]) || funct3 == 3'b010 || funct3 == 3'b011;
  assign add_full = {1'b0, a} + {1'b0, sub ? ~b : b} + {{XLEN{1'b0}}, sub};
  assign sum = add_full[XLEN-1:0];
  assign cy = add_full[XLEN];
  assign v = (a[XLEN-1] ^ sum[XLEN-1]) & ~(a[XLEN-1] ^ b[XLEN-1] ^ sub);
  assign sra = $signed(a) >>> b[SHW-1:0];
  assign base_res = funct3 == 3'b000 ? sum :
                    funct3 == 3'b001 ? a << b[SHW-1:0] :
                    funct3 == 3'b010 ? {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ v} :
                    funct3 == 3'b011 ? {{(XLEN-1){1'b0}}, ~cy} :
                    funct3 == 3'b100 ? a ^ b :
                    funct3 == 3'b101 ? (funct7[5] ? sra : a >> b[SHW-1:0]) :
                    funct3 == 3'b110 ? a | b : a & b;
  // operand signedness: mul ops by funct3[1:0], div/rem ops by funct3[0]
  assign asg = funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11;
  assign bsg = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign an = asg & a[XLEN-1];
  assign bn = bsg & b[XLEN-1];
  assign ma = an ? -a : a;
  assign mb = bn ? -b : b;
  assign dz = b == '0;
  assign ovf = ~funct3[0] && a == int_min && b == '1;
  // shift-add: low half of acc holds the multiplier, consumed LSB first
  assign msum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
  // restoring divide: acc = {remainder, quotient/dividend}
  assign rsh = acc[2*XLEN-1:XLEN-1];
  assign diff = rsh - {1'b0, opd};
  assign step = state == MUL ? {msum, acc[XLEN-1:1]} :
                diff[XLEN] ? {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign prod = neg ? -step : step;
  assign dv = op[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
  assign fin = state == MUL ? (op == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : (neg ? -dv : dv);
  assign last = cnt == CW'(XLEN - 1);

  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end

  // next state: an accept always wins over releasing or finishing
  always_comb begin
    state_n = state;
    if (fire) state_n = !m_op ? DONE : !funct3[2] ? MUL : (dz || ovf) ? DONE : DIV;
    else if (state == DONE && out_ready) state_n = IDLE;
    else if (busy && last) state_n = DONE;
  end

  // datapath: capture on accept, iterate while busy, hold result otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      alu_flags <= '0;
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      op <= '0;
      neg <= 1'b0;
    end else if (fire) begin
      op <= funct3[1:0];
      neg <= (funct3[2] & funct3[1]) ? an : an ^ bn;
      cnt <= '0;
      alu_flags <= m_op ? 4'b0 : {v, cy, sum[XLEN-1], sum == '0};
      if (!m_op) result <= base_res;
      else if (!funct3[2]) begin
        acc <= {{XLEN{1'b0}}, mb};
        opd <= ma;
      end else if (dz || ovf) result <= funct3[1] ? (dz ? a : '0) : (dz ? '1 : int_min);
      else begin
        acc <= {{XLEN{1'b0}}, ma};
        opd <= mb;
      end
    end else if (busy) begin
      acc <= step;
      cnt <= cnt + 1'b1;
      if (last) result <= fin;
    end
  end
endmodule

// File: tb/tb_seq_alu_m.sv
// tb_seq_alu_m: randomized and directed checks of seq_alu_m against a behavioural model
module tb_seq_alu_m;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [6:0] funct7 = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] a = 0, b = 0, result;
  logic [3:0] alu_flags;
  int n_cmp = 0, n_err = 0, cyc = 0;
  bit rand_or = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  seq_alu_m #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct7(funct7), .funct3(funct3), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_flags(alu_flags), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected result, flags and latency straight from the RISC-V definitions
  function automatic void model(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r, output logic [3:0] fl,
                                output int lat);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic [31:0] s;
    logic c, v, sb;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r = '0;
    fl = '0;
    lat = 1;
    if (f7 == 7'd1) begin
      lat = 33;
      case (f3)
        3'd0: begin p = sx * sy; r = p[31:0]; end
        3'd1: begin p = sx * sy; r = p[63:32]; end
        3'd2: begin p = sx * uy; r = p[63:32]; end
        3'd3: begin p = ux * uy; r = p[63:32]; end
        default: begin
          if (y == 0) begin
            lat = 1;
            r = f3[1] ? x : 32'hFFFFFFFF;
          end else if (!f3[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            lat = 1;
            r = f3[1] ? 32'h0 : 32'h80000000;
          end else begin
            if (f3[0]) p = f3[1] ? ux % uy : ux / uy;
            else p = f3[1] ? sx % sy : sx / sy;
            r = p[31:0];
          end
        end
      endcase
    end else begin
      sb = (f3 == 3'd0 && f7[5]) || f3 == 3'd2 || f3 == 3'd3;
      if (sb) begin
        s = x - y;
        c = x >= y;
        v = (x[31] != y[31]) && (s[31] != x[31]);
      end else begin
        p = ux + uy;
        s = p[31:0];
        c = p[32];
        v = (x[31] == y[31]) && (s[31] != x[31]);
      end
      fl = {v, c, s[31], s == 0};
      case (f3)
        3'd0: r = s;
        3'd1: r = x << y[4:0];
        3'd2: r = {31'b0, sx < sy};
        3'd3: r = {31'b0, x < y};
        3'd4: r = x ^ y;
        3'd5: begin p = f7[5] ? sx >>> y[4:0] : ux >> y[4:0]; r = p[31:0]; end
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end
  endfunction

  // scoreboard: every cycle compare handshake/busy, and result/flags while valid
  always @(negedge clk) begin
    exp_t e;
    bit ev, eir;
    cyc++;
    if (rst) q.delete();
    else begin
      ev = q.size() > 0 && cyc - q[0].acc >= q[0].lat;
      eir = q.size() == 0 || (ev && out_ready);
      check("out_valid", out_valid, ev);
      check("busy", busy, q.size() > 0 && !ev && q[0].lat > 1);
      check("in_ready", in_ready, eir);
      if (ev) begin
        check("result", result, q[0].res);
        check("alu_flags", alu_flags, q[0].fl);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && eir) begin
        model(funct7, funct3, a, b, e.res, e.fl, e.lat);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = ($urandom % 4) != 0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  // present an op and return just after the edge that accepts it; in_valid stays high
  task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] x,
                      input logic [31:0] y, output int waits);
    funct7 = f7;
    funct3 = f3;
    a = x;
    b = y;
    in_valid = 1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] rf7();
    case ($urandom % 4)
      0: return 7'h00;
      1: return 7'h20;
      2: return 7'h01;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    int w, n;
    logic [2:0] mf3 [3] = '{3'd0, 3'd1, 3'd3};
    logic [31:0] mexp [3] = '{32'h1, 32'h0, 32'hFFFFFFFE};
    logic [2:0] df3 [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] da [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd9, 32'h80000000, 32'h80000000};
    logic [31:0] db [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] dexp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'h0};
    int dlat [6] = '{33, 33, 1, 1, 1, 1};
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_flags", alu_flags, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 0;
    send(7'h00, 3'd0, 32'h7FFFFFFF, 32'h1, w);
    in_valid = 0;
    check("add_valid", out_valid, 1);
    check("add_result", result, 32'h80000000);
    check("add_flags", alu_flags, 4'b1010);
    @(posedge clk);
    #1;
    send(7'h20, 3'd0, 32'd5, 32'd5, w);
    check("sub_result", result, 0);
    check("sub_flags", alu_flags, 4'b0101);
    send(7'h00, 3'd3, 32'd1, 32'd2, w);
    check("sltu_wait", w, 0);
    check("sltu_result", result, 1);
    send(7'h20, 3'd5, 32'h80000000, 32'd4, w);
    check("sra_wait", w, 0);
    check("sra_result", result, 32'hF8000000);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      send(7'h01, mf3[i], 32'hFFFFFFFF, 32'hFFFFFFFF, w);
      in_valid = 0;
      check("mul_busy", busy, 1);
      wait_valid(n);
      check("mul_latency", n, 33);
      check("mul_result", result, mexp[i]);
    end
    for (int i = 0; i < 6; i++) begin
      send(7'h01, df3[i], da[i], db[i], w);
      in_valid = 0;
      wait_valid(n);
      check("div_latency", n, dlat[i]);
      check("div_result", result, dexp[i]);
    end
    @(posedge clk);
    #1;
    out_ready = 0;
    send(7'h00, 3'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, w);
    check("xor_result", result, 32'hAAAAAAAA);
    funct7 = 7'h00;
    funct3 = 3'd0;
    a = 32'd10;
    b = 32'd20;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_result", result, 32'hAAAAAAAA);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    check("bp_pending_valid", out_valid, 1);
    check("bp_pending_result", result, 32'd30);
    send(7'h01, 3'd5, 32'h12345678, 32'd3, w);
    in_valid = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_flags", alu_flags, 0);
    check("rstmid_result", result, 0);
    send(7'h00, 3'd0, 32'd3, 32'd4, w);
    in_valid = 0;
    check("post_rst_add", result, 32'd7);
    rand_or = 1;
    repeat (400) begin
      if ($urandom % 3 == 0) begin
        in_valid = 0;
        repeat ($urandom % 3 + 1) begin
          @(posedge clk);
          #1;
        end
      end
      send(rf7(), 3'($urandom), pick(), pick(), w);
    end
    in_valid = 0;
    rand_or = 0;
    out_ready = 1;
    repeat (40) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_alu_m.md
Name: seq_alu_m

Overview:
- Parametrised, multi-cycle successor of the core's single-cycle integer ALU.
- Executes every RV32I ALU operation in one registered cycle, plus the full RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with an iterative shift-add multiplier and a restoring divider.
- Sits in the EX stage behind a valid/ready handshake so the pipeline can stall on long operations.
- Reports {V,C,N,Z} flags for the base add/sub path.

Parameters:
- XLEN, 32, datapath width; power of two, >= 8.
- SHW, $clog2(XLEN), derived localparam: shift-amount width.
- CW, $clog2(XLEN+1), derived localparam: iteration-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- funct7  in  7  RISC-V funct7.
- funct3  in  3  RISC-V funct3.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  operation result.
- alu_flags  out  4  {V,C,N,Z} of add/sub path; 0 for M ops.
- busy  out  1  multiply/divide iteration in progress.

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high. Any edge with rst=1 forces state IDLE and drives out_valid=0, result=0, alu_flags=0, busy=0, counter=0. In-flight operations are discarded; rst dominates all other inputs.
- Accept: on an edge with in_valid & in_ready, capture funct7, funct3, a and b. Input changes afterwards are ignored until the next accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Decode:
  - funct7==0000001 selects an M op, indexed by funct3.
  - Any other funct7 selects a base op; funct7[5] selects SUB (funct3=000) or SRA (funct3=101).
  - Base ops: 000 ADD/SUB; 001 SLL; 010 SLT (N^V); 011 SLTU (~carry); 100 XOR; 101 SRL/SRA; 110 OR; 111 AND.
  - Shift amount is b[SHW-1:0].
  - SUB is computed as a + ~b + 1.
  - Flags: V = (a[msb]^sum[msb]) & ~(a[msb]^b[msb]^sub); C = carry-out; N = sum[msb]; Z = (sum==0). Flags are valid for all base ops and are 0 for M ops.
- States:
  - IDLE: waiting for a request.
  - MUL: iterative multiply.
  - DIV: iterative divide.
  - DONE: result held for the consumer.
- Transitions:
  - IDLE/DONE --accept base--> DONE. Result is registered, so latency is 1 edge.
  - IDLE/DONE --accept MUL*--> MUL. Operands are converted to magnitudes per signedness (MULHSU: a signed, b unsigned). Each edge performs one shift-add step on a 2*XLEN accumulator. After XLEN steps, go to DONE with the sign-corrected low half (MUL) or high half (MULH*). Latency is XLEN+1 edges.
  - IDLE/DONE --accept DIV*/REM*--> DIV. One restoring step per edge; after XLEN steps go to DONE with the sign-corrected quotient or remainder. Latency is XLEN+1 edges.
  - Divide by zero bypasses DIV and reaches DONE in 1 edge. Quotient = all ones; remainder = a.
  - Signed overflow (a = MIN, b = -1) bypasses DIV and reaches DONE in 1 edge. Quotient = MIN; remainder = 0.
  - Remainder sign follows the dividend; quotient truncates toward zero.
  - DONE: out_valid=1 and result/alu_flags held stable until out_ready. If out_ready=1 and there is no accept, go to IDLE. If out_ready=1 with a simultaneous accept, take the new op's transition; back-to-back base ops therefore sustain 1 result per cycle.
- Outputs:
  - busy = 1 in MUL or DIV.
  - out_valid = 1 only in DONE.
  - result and alu_flags are undefined-free (held at their last value) when out_valid=0.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> one edge after accept: out_valid=1, result=0x80000000, flags V=1 C=0 N=1 Z=0.
- SUB 5-5, then SLTU 1<2, then SRA 0x80000000>>4 sent back-to-back with out_ready=1 -> in_ready stays 1; results 0 (Z=1, C=1), 1, 0xF8000000 on consecutive cycles.
- MUL, MULH and MULHU with a=b=0xFFFFFFFF -> 0x00000001, 0x00000000, 0xFFFFFFFE respectively. Each has out_valid exactly 33 edges after accept and busy=1 for 32 cycles.
- Division results:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF (33 edges each).
  - DIVU 9/0 -> 0xFFFFFFFF and REMU 9/0 -> 9, each with 1-edge latency.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, each with 1-edge latency.
- Backpressure: XOR completes with out_ready=0 for 5 cycles -> result stable, in_ready=0, a concurrent in_valid is not accepted; out_ready=1 releases the result and the pending op is accepted on that same edge.
- Reset mid-op: rst=1 for one edge during iteration 10 of a DIVU -> next cycle state IDLE, in_ready=1, out_valid=0, busy=0, alu_flags=0; a following ADD 3+4 returns 7 after 1 edge.
